mario_anim_ctrl: RTL

- Per-frame animation sequencer for the player sprite.
- Decodes keycode and the physics on_ground flag once per video frame, runs the stand/walk/skid/jump state machine and walk cadence.
- Drives the frame-select base address and horizontal mirror used by the sprite ROM addressing in the color mapper.
- Sprite ROM stores 16x16 frames back to back, 256 words each. Frame indices: 0 stand, 1..3 walk, 4 jump, 5 skid.

---
 rtl/mario_anim_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mario_anim_ctrl.sv
// Purpose : per-frame player sprite animation sequencer (stand/walk/skid/jump, walk cadence, facing).
// Latency : state and outputs update 2 Clk edges after a frame_clk rising edge (sync + register).
// Backpr. : none; free-running, consumes one frame tick per frame_clk rising edge.
//
// Ports:
//   Clk, Reset          - system clock, synchronous active-high reset
//   frame_clk           - vsync-rate strobe, asynchronous to Clk
//   keycode, on_ground  - keyboard code and physics grounded flag, sampled on frame ticks
//   frame_idx/base_addr - selected sprite frame (0..5) and its ROM base {frame_idx, 8'h00}
//   mirror              - 1 = draw horizontally mirrored (facing left, or turn pose in skid)
//   anim_state          - 0 STAND, 1 WALK, 2 SKID, 3 JUMP
//   jump_start          - one-Clk pulse when a jump is launched
module mario_anim_ctrl #(
   parameter logic [7:0] KEY_RIGHT  = 8'h07,
   parameter logic [7:0] KEY_LEFT   = 8'h04,
   parameter logic [7:0] KEY_JUMP   = 8'h1A,
   parameter int         WALK_DIV   = 6,
   parameter int         SKID_TICKS = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   input  logic [7:0]  keycode,
   input  logic        on_ground,
   output logic [2:0]  frame_idx,
   output logic [10:0] base_addr,
   output logic        mirror,
   output logic [1:0]  anim_state,
   output logic        jump_start
);

   localparam int CW = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;
   localparam int SW = (SKID_TICKS > 1) ? $clog2(SKID_TICKS) : 1;
   localparam logic [CW-1:0] CAD_LAST  = CW'(WALK_DIV - 1);
   localparam logic [SW-1:0] SKID_LAST = SW'(SKID_TICKS - 1);

   typedef enum logic [1:0] {
      ST_STAND = 2'd0,
      ST_WALK  = 2'd1,
      ST_SKID  = 2'd2,
      ST_JUMP  = 2'd3
   } state_t;

   // frame_clk synchroniser / edge detector
   logic fc1, fc2;
   logic tick;
   assign tick = fc1 & ~fc2;

   logic key_right, key_left, key_jump;
   assign key_right = (keycode == KEY_RIGHT);
   assign key_left  = (keycode == KEY_LEFT);
   assign key_jump  = (keycode == KEY_JUMP);

   // facing: 0 = right, 1 = left
   state_t         state_q, state_d;
   logic           facing_q, facing_d;
   logic [CW-1:0]  cad_q, cad_d;
   logic [1:0]     phase_q, phase_d;
   logic [SW-1:0]  skid_q, skid_d;
   logic           air_seen_q, air_seen_d;
   logic           jump_armed_q, jump_armed_d;
   logic [1:0]     jump_cnt_q, jump_cnt_d;
   logic           launch;
   logic [2:0]     frame_d;
   logic           mirror_d;

   always_comb begin
      state_d      = state_q;
      facing_d     = facing_q;
      cad_d        = cad_q;
      phase_d      = phase_q;
      skid_d       = skid_q;
      air_seen_d   = air_seen_q;
      jump_armed_d = jump_armed_q;
      jump_cnt_d   = jump_cnt_q;
      launch       = 1'b0;

      if (tick) begin
         // Re-arm only once the jump key has been seen released on a tick.
         if (!key_jump)
            jump_armed_d = 1'b1;

         if (state_q != ST_JUMP) begin
            if (key_jump && jump_armed_q && on_ground) begin
               launch       = 1'b1;
               state_d      = ST_JUMP;
               air_seen_d   = 1'b0;
               jump_cnt_d   = 2'd0;
               jump_armed_d = 1'b0;
            end else if (!on_ground) begin
               // Walked off a ledge: airborne without a launch pulse.
               state_d    = ST_JUMP;
               air_seen_d = 1'b0;
               jump_cnt_d = 2'd0;
            end else begin
               case (state_q)
                  ST_STAND: begin
                     if (key_right || key_left) begin
                        facing_d = key_left;
                        state_d  = ST_WALK;
                        phase_d  = 2'd0;
                        cad_d    = '0;
                     end
                  end
                  ST_WALK: begin
                     if (!key_right && !key_left) begin
                        state_d = ST_STAND;
                     end else if (key_left != facing_q) begin
                        state_d = ST_SKID;
                        skid_d  = '0;
                     end else if (cad_q == CAD_LAST) begin
                        cad_d   = '0;
                        phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                     end else begin
                        cad_d = cad_q + CW'(1);
                     end
                  end
                  ST_SKID: begin
                     if (!key_right && !key_left) begin
                        state_d = ST_STAND;
                     end else if (key_left == facing_q) begin
                        state_d = ST_WALK;
                        phase_d = 2'd0;
                        cad_d   = '0;
                     end else if (skid_q == SKID_LAST) begin
                        facing_d = ~facing_q;
                        state_d  = ST_WALK;
                        phase_d  = 2'd0;
                        cad_d    = '0;
                     end else begin
                        skid_d = skid_q + SW'(1);
                     end
                  end
                  default: ;
               endcase
            end
         end else begin
            // Saturating tick count since entry; only the value 1 matters.
            if (jump_cnt_q != 2'd3)
               jump_cnt_d = jump_cnt_q + 2'd1;

            if (on_ground && air_seen_q) begin
               if (key_right || key_left) begin
                  facing_d = key_left;
                  state_d  = ST_WALK;
                  phase_d  = 2'd0;
                  cad_d    = '0;
               end else begin
                  state_d = ST_STAND;
               end
            end else if (on_ground && (jump_cnt_q == 2'd1)) begin
               // Never left the ground (blocked launch): give up the jump.
               state_d = ST_STAND;
            end else if (!on_ground) begin
               air_seen_d = 1'b1;
            end
         end
      end
   end

   // Output decode from next state so outputs register at the same edge as state.
   always_comb begin
      frame_d  = 3'd0;
      mirror_d = facing_d;
      case (state_d)
         ST_STAND: frame_d = 3'd0;
         ST_WALK:  frame_d = 3'd1 + {1'b0, phase_d};
         ST_JUMP:  frame_d = 3'd4;
         ST_SKID: begin
            frame_d  = 3'd5;
            mirror_d = ~facing_d;   // turn pose faces the new direction
         end
         default:  frame_d = 3'd0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         fc1          <= 1'b0;
         fc2          <= 1'b0;
         state_q      <= ST_STAND;
         facing_q     <= 1'b0;
         cad_q        <= '0;
         phase_q      <= 2'd0;
         skid_q       <= '0;
         air_seen_q   <= 1'b0;
         jump_armed_q <= 1'b1;
         jump_cnt_q   <= 2'd0;
         frame_idx    <= 3'd0;
         base_addr    <= 11'd0;
         mirror       <= 1'b0;
         anim_state   <= 2'd0;
         jump_start   <= 1'b0;
      end else begin
         fc1          <= frame_clk;
         fc2          <= fc1;
         state_q      <= state_d;
         facing_q     <= facing_d;
         cad_q        <= cad_d;
         phase_q      <= phase_d;
         skid_q       <= skid_d;
         air_seen_q   <= air_seen_d;
         jump_armed_q <= jump_armed_d;
         jump_cnt_q   <= jump_cnt_d;
         frame_idx    <= frame_d;
         base_addr    <= {frame_d, 8'h00};
         mirror       <= mirror_d;
         anim_state   <= state_d;
         jump_start   <= launch;
      end
   end

endmodule
